// File: rtl/slave_port.sv
// slave_port: bit-serial bus slave. Deserialises a 24-bit frame (16 address
// bits, then 8 data bits, both LSB first), matches the top address nibble
// against SLAVE_ID and issues one write to the local memory side. When the
// memory accepts the write, a single-cycle acknowledge goes back to the bus.
module slave_port #(
    parameter logic [3:0] SLAVE_ID = 4'h0,
    parameter int         ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sp_valid,
    input  logic              sp_addr,
    input  logic              sp_wdata,
    output logic              sp_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wen,
    input  logic              s_ready
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        RESP
    } state_t;

    state_t            state_reg,   state_next;
    logic [3:0]        cnt_reg,     cnt_next;
    logic [15:0]       addr_sr_reg, addr_sr_next;
    logic [7:0]        data_sr_reg, data_sr_next;
    logic [ADDR_W-1:0] s_addr_reg,  s_addr_next;
    logic [7:0]        s_wdata_reg, s_wdata_next;
    logic              s_wen_reg,   s_wen_next;
    logic              sp_ready_reg, sp_ready_next;

    // The last data bit arrives in the same cycle the select is evaluated,
    // so the complete byte is formed from the live input plus bits 0..6.
    logic [7:0]        data_full;
    assign data_full = {sp_wdata, data_sr_reg[6:0]};

    assign s_addr   = s_addr_reg;
    assign s_wdata  = s_wdata_reg;
    assign s_wen    = s_wen_reg;
    assign sp_ready = sp_ready_reg;

    // State and output registers; reset clears everything at once so a
    // pending write request drops without waiting for a clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_sr_reg  <= 16'd0;
            data_sr_reg  <= 8'd0;
            s_addr_reg   <= '0;
            s_wdata_reg  <= 8'd0;
            s_wen_reg    <= 1'b0;
            sp_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_sr_reg  <= addr_sr_next;
            data_sr_reg  <= data_sr_next;
            s_addr_reg   <= s_addr_next;
            s_wdata_reg  <= s_wdata_next;
            s_wen_reg    <= s_wen_next;
            sp_ready_reg <= sp_ready_next;
        end
    end

    // Next-state logic: frame deserialisation, select, write handshake, ack.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_sr_next  = addr_sr_reg;
        data_sr_next  = data_sr_reg;
        s_addr_next   = s_addr_reg;
        s_wdata_next  = s_wdata_reg;
        s_wen_next    = s_wen_reg;
        sp_ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                s_wen_next = 1'b0;
                if (sp_valid) begin
                    // Bit 0 is taken in the very first valid cycle.
                    addr_sr_next = {15'd0, sp_addr};
                    data_sr_next = 8'd0;
                    cnt_next     = 4'd1;
                    state_next   = ADDR;
                end
            end

            ADDR: begin
                if (!sp_valid) begin
                    // Frame aborted: partial contents are thrown away.
                    addr_sr_next = 16'd0;
                    data_sr_next = 8'd0;
                    cnt_next     = 4'd0;
                    state_next   = IDLE;
                end else begin
                    addr_sr_next[cnt_reg] = sp_addr;
                    // Counter stops at 15; leaving the state is what resets it.
                    if (cnt_reg == 4'd15) begin
                        cnt_next   = 4'd0;
                        state_next = DATA;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end

            DATA: begin
                if (!sp_valid) begin
                    addr_sr_next = 16'd0;
                    data_sr_next = 8'd0;
                    cnt_next     = 4'd0;
                    state_next   = IDLE;
                end else begin
                    data_sr_next[cnt_reg[2:0]] = sp_wdata;
                    if (cnt_reg >= 4'd7) begin
                        cnt_next = 4'd0;
                        if (addr_sr_reg[15:12] == SLAVE_ID) begin
                            s_addr_next  = addr_sr_reg[ADDR_W-1:0];
                            s_wdata_next = data_full;
                            s_wen_next   = 1'b1;
                            state_next   = WRITE;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end

            WRITE: begin
                // Hold the request indefinitely; memory decides when.
                s_wen_next = 1'b1;
                if (s_ready) begin
                    s_wen_next    = 1'b0;
                    sp_ready_next = 1'b1;
                    state_next    = RESP;
                end
            end

            RESP: begin
                s_wen_next = 1'b0;
                state_next = IDLE;
            end

            default: begin
                s_wen_next = 1'b0;
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 4'h0, meaning the slave select value compared against address bits [15:12].
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the local address width delivered to the memory side.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sp_valid, input, 1 bit: bus frame valid, high for every bit-cycle of a frame.
REQ-006 SHALL have port sp_addr, input, 1 bit: serial address bit, LSB first.
REQ-007 SHALL have port sp_wdata, input, 1 bit: serial write-data bit, LSB first.
REQ-008 SHALL have port sp_ready, output, 1 bit: one-cycle write-complete acknowledge to the bus.
REQ-009 SHALL have port s_addr, output, ADDR_W bits: local memory address.
REQ-010 SHALL have port s_wdata, output, 8 bits: local memory write data.
REQ-011 SHALL have port s_wen, output, 1 bit: memory write request.
REQ-012 SHALL have port s_ready, input, 1 bit: memory accepts the write in any cycle where s_wen and s_ready are both high.

Function
REQ-013 SHALL implement the states IDLE, ADDR, DATA, WRITE and RESP.
REQ-014 SHALL frame each bus transfer as 24 consecutive sp_valid-high cycles: 16 cycles of sp_addr bits 0..15, then 8 cycles of sp_wdata bits 0..7; sp_addr is ignored in DATA and sp_wdata is ignored in ADDR.
REQ-015 IDLE: on sp_valid=1, SHALL capture address bit 0 in that same cycle and move to ADDR with bit counter=1.
REQ-016 ADDR: SHALL shift in one sp_addr bit per cycle; after bit 15 is captured, SHALL move to DATA with counter=0.
REQ-017 DATA: SHALL shift in one sp_wdata bit per cycle; after bit 7 is captured, SHALL evaluate the select.
REQ-018 Select match (addr[15:12]==SLAVE_ID) SHALL load s_addr=addr[ADDR_W-1:0] and s_wdata=data, and move to WRITE.
REQ-019 Select mismatch SHALL return to IDLE with no s_wen and no sp_ready.
REQ-020 WRITE: SHALL hold s_wen=1 with s_addr and s_wdata stable until s_ready=1 is sampled, then move to RESP; there is no timeout.
REQ-021 RESP: SHALL drive sp_ready=1 for exactly one cycle, then return to IDLE.
REQ-022 WRITE-to-sp_ready latency SHALL be one cycle after the s_wen/s_ready handshake cycle.
REQ-023 If s_ready is already high on WRITE entry, SHALL complete the handshake in the first WRITE cycle.
REQ-024 sp_valid=0 during ADDR or DATA SHALL abort the frame: return to IDLE, discard the partial shift register, no s_wen, no sp_ready.
REQ-025 sp_valid SHALL be ignored in WRITE and RESP; a new frame SHALL only be accepted from IDLE.
REQ-026 The bit counter SHALL be 4 bits wide, saturate at its terminal count per state (15 in ADDR, 7 in DATA) and never wrap silently.
REQ-027 s_wen and sp_ready SHALL be registered outputs and never both high in the same cycle.
REQ-028 Back-to-back frames SHALL be accepted: sp_valid high in the first IDLE cycle after RESP starts a new frame.

Reset
REQ-029 rstn=0 SHALL asynchronously force state=IDLE, counter=0, shift registers=0, s_addr=0, s_wdata=0, s_wen=0 and sp_ready=0.
REQ-030 Reset asserted mid-frame or during WRITE SHALL drop s_wen immediately; after release the block SHALL wait in IDLE for a fresh sp_valid.

Verification
REQ-031 Serial frame addr=16'h0234, data=8'h75, SLAVE_ID=0, s_ready=1 -> s_wen high with s_addr=12'h234 and s_wdata=8'h75, then sp_ready pulses for one cycle.
REQ-032 Same frame with addr=16'h1234, SLAVE_ID=0 -> no s_wen and no sp_ready; the block is back in IDLE after cycle 24.
REQ-033 sp_valid dropped after 10 address bits -> IDLE, no s_wen; a following full frame addr=16'h0010, data=8'hA5 writes correctly.
REQ-034 s_ready held low for 5 cycles in WRITE -> s_wen and its data held stable for 5 cycles; sp_ready 1 cycle after s_ready rises.
REQ-035 rstn pulsed low during DATA bit 4 -> all outputs 0 immediately; the next full frame completes normally.
REQ-036 Two back-to-back frames (addr 0x0001/data 0x11, addr 0x0002/data 0x22) -> two writes in order and two sp_ready pulses.
